// File: rtl/sdram_arb_pkg.sv
// +----------------------------------------------------------------------+
// | sdram_arb_pkg : shared types and helpers for sdram_bus_arbiter       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package sdram_arb_pkg;

    localparam int MAX_BEATS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CMD   = 2'd1,
        RDATA = 2'd2
    } arb_state_t;

    // Codes 4..7 all saturate at the 8-beat maximum.
    function automatic logic [3:0] burst_beats(input logic burst, input logic [2:0] burst_len);
        if (!burst) begin
            return 4'd1;
        end else if (burst_len[2]) begin
            return 4'd8;
        end else begin
            return 4'd1 << burst_len[1:0];
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_bus_arbiter_rr_arbiter.sv
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational circular priority search from ptr         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   idx
);

    int   cand;
    logic found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            cand = int'(ptr) + i;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = PW'(cand);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/sdram_bus_arbiter.sv
// +----------------------------------------------------------------------+
// | sdram_bus_arbiter : round-robin owner arbitration for the SDRAM bus  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module sdram_bus_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 23,
    parameter int DW   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        m_req_read,
    input  logic [NREQ-1:0]        m_req_write,
    input  logic [NREQ*AW-1:0]     m_req_addr,
    input  logic [NREQ-1:0]        m_req_burst,
    input  logic [NREQ*3-1:0]      m_req_burst_len,
    input  logic [NREQ*DW-1:0]     m_req_wdata,
    input  logic [NREQ*DW/8-1:0]   m_req_byteenable,
    output logic [NREQ-1:0]        m_req_ready,
    output logic [NREQ-1:0]        m_rsp_valid,
    output logic [DW-1:0]          m_rsp_rdata,
    output logic [NREQ-1:0]        m_grant,
    output logic                   s_req_read,
    output logic                   s_req_write,
    output logic [AW-1:0]          s_req_addr,
    output logic                   s_req_burst,
    output logic [2:0]             s_req_burst_len,
    output logic [DW-1:0]          s_req_wdata,
    output logic [DW/8-1:0]        s_req_byteenable,
    input  logic                   s_req_ready,
    input  logic                   s_rsp_valid,
    input  logic [DW-1:0]          s_rsp_rdata
);

    localparam int PW = $clog2(NREQ);
    localparam int BW = DW / 8;
    localparam int CW = $clog2(MAX_BEATS) + 1;

    arb_state_t      state;
    logic [PW-1:0]   owner;
    logic [PW-1:0]   rr_ptr;
    logic [NREQ-1:0] grant;
    logic [CW-1:0]   beats;
    logic            started;

    logic [NREQ-1:0] req_any;
    logic [NREQ-1:0] win_onehot;
    logic [PW-1:0]   win_idx;
    logic [PW-1:0]   next_ptr;
    logic            own_read;
    logic            own_write;
    logic            in_cmd;
    logic            in_rdata;

    assign req_any   = m_req_read | m_req_write;
    assign own_read  = m_req_read[owner];
    assign own_write = m_req_write[owner];
    assign in_cmd    = (state == CMD);
    assign in_rdata  = (state == RDATA);
    assign next_ptr  = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arbiter (
        .req   (req_any),
        .ptr   (rr_ptr),
        .grant (win_onehot),
        .idx   (win_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= '0;
            rr_ptr  <= '0;
            grant   <= '0;
            beats   <= '0;
            started <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_any) begin
                        owner   <= win_idx;
                        grant   <= win_onehot;
                        beats   <= burst_beats(m_req_burst[win_idx], m_req_burst_len[win_idx*3 +: 3]);
                        rr_ptr  <= next_ptr;
                        started <= 1'b0;
                        state   <= CMD;
                    end
                end
                CMD: begin
                    if (own_read) begin
                        if (s_req_ready) begin
                            state <= RDATA;
                        end
                    end else if (own_write) begin
                        if (s_req_ready) begin
                            started <= 1'b1;
                            beats   <= beats - 1'b1;
                            if (beats == CW'(1)) begin
                                state <= IDLE;
                                grant <= '0;
                            end
                        end
                    end else if (!started) begin
                        // Owner withdrew before any beat moved: release without bus traffic.
                        state <= IDLE;
                        grant <= '0;
                        beats <= '0;
                    end
                end
                RDATA: begin
                    if (s_rsp_valid) begin
                        beats <= beats - 1'b1;
                        if (beats == CW'(1)) begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

    // Forwarding is a pure mux off the registered owner, so each beat costs no extra cycle.
    always_comb begin
        s_req_read       = 1'b0;
        s_req_write      = 1'b0;
        s_req_addr       = '0;
        s_req_burst      = 1'b0;
        s_req_burst_len  = '0;
        s_req_wdata      = '0;
        s_req_byteenable = '0;
        m_req_ready      = '0;
        if (in_cmd) begin
            s_req_read       = own_read;
            s_req_write      = own_write & ~own_read;
            s_req_addr       = m_req_addr[owner*AW +: AW];
            s_req_burst      = m_req_burst[owner];
            s_req_burst_len  = m_req_burst_len[owner*3 +: 3];
            s_req_wdata      = m_req_wdata[owner*DW +: DW];
            s_req_byteenable = m_req_byteenable[owner*BW +: BW];
            m_req_ready      = s_req_ready ? grant : '0;
        end
    end

    assign m_rsp_valid = (in_rdata && s_rsp_valid) ? grant : '0;
    assign m_rsp_rdata = in_rdata ? s_rsp_rdata : '0;
    assign m_grant     = grant;

endmodule

`default_nettype wire
